seq_tx: RTL and testbench

Serial pattern transmitter: accepts a pattern word with a bit length and a repeat count, then drives it bit-serially, LSB first, one bit per clock. It is the transmit-side counterpart to the team's serial sequence detectors. Its `x_o` and `vld_o` feed a detector's serial input in benches and in the integrated datapath. It provides a load handshake, frame markers, a repeat/gap engine, and a completion pulse.

---
 rtl/seq_tx.sv | 166 ++++++++++++++++
 tb/tb_seq_tx.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seq_tx.sv
// ============================================================================
// seq_tx : LSB-first serial pattern transmitter with repeat/gap engine
// Rev 1.0
// ============================================================================
`default_nettype none

module seq_tx #(
  parameter int MAX_W   = 16,
  parameter int LEN_W   = 5,
  parameter int CNT_W   = 4,
  parameter int GAP_CYC = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [MAX_W-1:0] pat_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [CNT_W-1:0] rep_i,
  input  logic             abort_i,
  output logic             ready_o,
  output logic             x_o,
  output logic             vld_o,
  output logic             last_o,
  output logic             done_o
);

  localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYC > 0) ? GAP_W'(GAP_CYC - 1) : '0;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MAX_W);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [MAX_W-1:0] shreg, shreg_nxt;
  logic [MAX_W-1:0] pat_q, pat_q_nxt;
  logic [LEN_W-1:0] len_q, len_q_nxt;
  logic [LEN_W-1:0] bitcnt, bitcnt_nxt;
  logic [CNT_W-1:0] repcnt, repcnt_nxt;
  logic [GAP_W-1:0] gapcnt, gapcnt_nxt;
  logic             fin, fin_nxt;
  logic             ready_nxt, x_nxt, vld_nxt, last_nxt, done_nxt;
  logic [LEN_W-1:0] len_eff;

  assign len_eff = (len_i > LEN_MAX) ? LEN_MAX : len_i;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      bitcnt  <= '0;
      repcnt  <= '0;
      gapcnt  <= '0;
      fin     <= 1'b0;
      ready_o <= 1'b1;
      x_o     <= 1'b0;
      vld_o   <= 1'b0;
      last_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state   <= state_nxt;
      shreg   <= shreg_nxt;
      pat_q   <= pat_q_nxt;
      len_q   <= len_q_nxt;
      bitcnt  <= bitcnt_nxt;
      repcnt  <= repcnt_nxt;
      gapcnt  <= gapcnt_nxt;
      fin     <= fin_nxt;
      ready_o <= ready_nxt;
      x_o     <= x_nxt;
      vld_o   <= vld_nxt;
      last_o  <= last_nxt;
      done_o  <= done_nxt;
    end
  end

  // Outputs are registered, so each branch computes what the pins show after this edge.
  always_comb begin
    state_nxt  = state;
    shreg_nxt  = shreg;
    pat_q_nxt  = pat_q;
    len_q_nxt  = len_q;
    bitcnt_nxt = bitcnt;
    repcnt_nxt = repcnt;
    gapcnt_nxt = gapcnt;
    fin_nxt    = 1'b0;
    ready_nxt  = 1'b0;
    x_nxt      = 1'b0;
    vld_nxt    = 1'b0;
    last_nxt   = 1'b0;
    done_nxt   = 1'b0;

    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        done_nxt  = fin;
        if (start_i && ready_o) begin
          pat_q_nxt  = pat_i;
          shreg_nxt  = pat_i;
          len_q_nxt  = len_eff;
          bitcnt_nxt = len_eff;
          repcnt_nxt = rep_i;
          if (len_eff == '0) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = SHIFT;
            ready_nxt = 1'b0;
          end
        end
      end

      SHIFT: begin
        if (abort_i) begin
          state_nxt = IDLE;
          ready_nxt = 1'b1;
        end else begin
          x_nxt      = shreg[0];
          vld_nxt    = 1'b1;
          shreg_nxt  = shreg >> 1;
          bitcnt_nxt = bitcnt - LEN_ONE;
          if (bitcnt == LEN_ONE) begin
            last_nxt = 1'b1;
            if (repcnt == '0) begin
              // done_o follows one cycle after the last bit via fin
              state_nxt = IDLE;
              fin_nxt   = 1'b1;
            end else begin
              repcnt_nxt = repcnt - 1'b1;
              shreg_nxt  = pat_q;
              bitcnt_nxt = len_q;
              if (GAP_CYC > 0) begin
                state_nxt  = GAP;
                gapcnt_nxt = GAP_LOAD;
              end
            end
          end
        end
      end

      GAP: begin
        if (abort_i) begin
          state_nxt = IDLE;
          ready_nxt = 1'b1;
        end else if (gapcnt == '0) begin
          state_nxt = SHIFT;
        end else begin
          gapcnt_nxt = gapcnt - 1'b1;
        end
      end

      default: begin
        state_nxt = IDLE;
        ready_nxt = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_tx.sv
// Directed bench for seq_tx: outputs compared as {ready,x,vld,last,done}.
`default_nettype none

module tb_seq_tx;

  logic        clk;
  logic        reset;
  logic        start_i;
  logic [15:0] pat_i;
  logic [4:0]  len_i;
  logic [3:0]  rep_i;
  logic        abort_i;
  logic        ready_o, x_o, vld_o, last_o, done_o;

  int checks = 0;
  int errors = 0;

  seq_tx #(.MAX_W(16), .LEN_W(5), .CNT_W(4), .GAP_CYC(1)) dut (
    .clk     (clk),
    .reset   (reset),
    .start_i (start_i),
    .pat_i   (pat_i),
    .len_i   (len_i),
    .rep_i   (rep_i),
    .abort_i (abort_i),
    .ready_o (ready_o),
    .x_o     (x_o),
    .vld_o   (vld_o),
    .last_o  (last_o),
    .done_o  (done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic expo(input string tag, input logic [4:0] e);
    logic [4:0] obs;
    obs = {ready_o, x_o, vld_o, last_o, done_o};
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, e);
    end
  endtask

  // n bits of p, LSB first, last_o on the final one
  task automatic grp(input string tag, input logic [15:0] p, input int n);
    for (int i = 0; i < n; i++) begin
      step();
      expo(tag, {1'b0, p[i], 1'b1, (i == n - 1), 1'b0});
    end
  endtask

  task automatic issue(input logic [15:0] p, input logic [4:0] l, input logic [3:0] r);
    start_i = 1'b1;
    pat_i   = p;
    len_i   = l;
    rep_i   = r;
  endtask

  initial begin
    reset   = 1'b1;
    start_i = 1'b0;
    pat_i   = '0;
    len_i   = '0;
    rep_i   = '0;
    abort_i = 1'b0;
    step();
    expo("reset_state", 5'b10000);
    reset = 1'b0;
    step();
    expo("idle_after_reset", 5'b10000);

    // 1: single repetition of 1101
    issue(16'h000B, 5'd4, 4'd0);
    step();
    expo("s1_accept", 5'b00000);
    start_i = 1'b0;
    grp("s1_bits", 16'h000B, 4);
    step();
    expo("s1_done", 5'b10001);
    step();
    expo("s1_idle", 5'b10000);

    // 2: three repetitions with one-cycle gaps
    issue(16'h000B, 5'd4, 4'd2);
    step();
    expo("s2_accept", 5'b00000);
    start_i = 1'b0;
    grp("s2_rep0", 16'h000B, 4);
    step();
    expo("s2_gap0", 5'b00000);
    grp("s2_rep1", 16'h000B, 4);
    step();
    expo("s2_gap1", 5'b00000);
    grp("s2_rep2", 16'h000B, 4);
    step();
    expo("s2_done", 5'b10001);
    step();
    expo("s2_idle", 5'b10000);

    // 3: start held high; new operands during frame 1 must not disturb it
    issue(16'h000B, 5'd4, 4'd0);
    step();
    expo("s3_accept1", 5'b00000);
    pat_i = 16'h0005;
    len_i = 5'd3;
    grp("s3_frame1", 16'h000B, 4);
    step();
    expo("s3_done1", 5'b10001);
    step();
    expo("s3_accept2", 5'b00000);
    start_i = 1'b0;
    grp("s3_frame2", 16'h0005, 3);
    step();
    expo("s3_done2", 5'b10001);

    // 4a: length clamped to 16
    issue(16'hA5C3, 5'd20, 4'd0);
    step();
    expo("s4_accept", 5'b00000);
    start_i = 1'b0;
    grp("s4_clamp", 16'hA5C3, 16);
    step();
    expo("s4_done", 5'b10001);
    step();
    expo("s4_idle", 5'b10000);

    // 4b: zero length, rep ignored
    issue(16'hFFFF, 5'd0, 4'd3);
    step();
    expo("s4_zero_done", 5'b10001);
    start_i = 1'b0;
    step();
    expo("s4_zero_idle", 5'b10000);
    step();
    expo("s4_zero_quiet", 5'b10000);

    // 5: abort during bit 2 of repetition 1, then start together with abort in IDLE
    issue(16'h000B, 5'd4, 4'd2);
    step();
    expo("s5_accept", 5'b00000);
    start_i = 1'b0;
    step();
    expo("s5_bit1", 5'b01100);
    step();
    expo("s5_bit2", 5'b01100);
    abort_i = 1'b1;
    step();
    expo("s5_aborted", 5'b10000);
    issue(16'h0005, 5'd3, 4'd0);
    step();
    expo("s5_restart", 5'b00000);
    start_i = 1'b0;
    abort_i = 1'b0;
    grp("s5_frame", 16'h0005, 3);
    step();
    expo("s5_done", 5'b10001);

    // 6: asynchronous reset mid-SHIFT
    issue(16'h000B, 5'd4, 4'd0);
    step();
    start_i = 1'b0;
    step();
    expo("s6_bit1", 5'b01100);
    #2 reset = 1'b1;
    #1 expo("s6_async_reset", 5'b10000);
    step();
    expo("s6_held", 5'b10000);
    reset = 1'b0;
    step();
    expo("s6_released", 5'b10000);
    issue(16'h000B, 5'd4, 4'd0);
    step();
    expo("s6_accept", 5'b00000);
    start_i = 1'b0;
    grp("s6_bits", 16'h000B, 4);
    step();
    expo("s6_done", 5'b10001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
